// File: rtl/mac_mem_pkg.sv
// Shared types and default sizing for the MAC matrix store and its
// multiply-accumulate engine.
package mac_mem_pkg;

  localparam int M_DEF  = 4;
  localparam int K_DEF  = 4;
  localparam int N_DEF  = 4;
  localparam int DW_DEF = 32;
  localparam int RW_DEF = 2 * DW_DEF + $clog2(K_DEF);

  localparam int ROW_A_AW = $clog2(M_DEF);
  localparam int COL_A_AW = $clog2(K_DEF);
  localparam int ROW_B_AW = $clog2(K_DEF);
  localparam int COL_B_AW = $clog2(N_DEF);
  localparam int ROW_C_AW = $clog2(M_DEF);
  localparam int COL_C_AW = $clog2(N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-add: acc <= (sel_init ? init : acc) + a*b when en.
// Sum wraps modulo 2^RW.
module mac_unit
  import mac_mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          sel_init,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [RW-1:0] init,
  output logic [RW-1:0] acc
);

  logic [2*DW-1:0] prod;
  logic [RW-1:0]   base;

  assign prod = (2*DW)'(a) * (2*DW)'(b);
  assign base = sel_init ? init : acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (en) begin
      acc <= base + RW'(prod);
    end
  end

endmodule

// File: rtl/mac_matmul_engine.sv
// Matrix store for A, B, C with host ports, plus a sequential engine computing
// C = A*B (or C += A*B), one product per cycle, one writeback per element.
//
// state | meaning
// IDLE  | host owns the memories; start launches a run
// MAC   | accumulate A[i][k]*B[k][j] for k = 0..K-1
// WB    | store acc into C[i][j], advance j/i, or finish with done
module mac_matmul_engine
  import mac_mem_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int DATA_WIDTH_INIT_MATRIX   = DW_DEF,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
  input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
  input  logic [$clog2(M)-1:0]                row_addr_a,
  input  logic [$clog2(K)-1:0]                col_addr_a,
  input  logic [$clog2(K)-1:0]                row_addr_b,
  input  logic [$clog2(N)-1:0]                col_addr_b,
  input  logic [$clog2(M)-1:0]                row_addr_c,
  input  logic [$clog2(N)-1:0]                col_addr_c,
  input  logic                                matrix_a_we,
  input  logic                                matrix_b_we,
  input  logic                                matrix_c_we,
  input  logic                                matrix_a_re,
  input  logic                                matrix_b_re,
  input  logic                                matrix_c_re,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
  input  logic                                start,
  input  logic                                accumulate,
  output logic                                busy,
  output logic                                done
);

  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int RW = DATA_WIDTH_RESULT_MATRIX;
  localparam int MW = $clog2(M);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);

  localparam logic [MW-1:0] I_LAST = MW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] J_LAST = NW'(N - 1);

  logic [DW-1:0] mem_a [M][K];
  logic [DW-1:0] mem_b [K][N];
  logic [RW-1:0] mem_c [M][N];

  state_t        state_q, state_d;
  logic [MW-1:0] i_q;
  logic [KW-1:0] k_q;
  logic [NW-1:0] j_q;
  logic          acc_mode_q;
  logic          last_elem;
  logic          host_wr_ok;
  logic [RW-1:0] acc;
  logic [RW-1:0] acc_init;

  assign busy       = (state_q != IDLE);
  assign host_wr_ok = (state_q == IDLE);
  assign last_elem  = (i_q == I_LAST) && (j_q == J_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (k_q == K_LAST) state_d = WB;
      WB:      state_d = last_elem ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc_mode_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state_q == WB) && last_elem;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_mode_q <= accumulate;
          end
        end
        MAC: begin
          k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
        WB: begin
          if (j_q == J_LAST) begin
            j_q <= '0;
            i_q <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Accumulate mode seeds the first product of each element with the old C value.
  assign acc_init = acc_mode_q ? mem_c[i_q][j_q] : '0;

  mac_unit #(
    .DW(DW),
    .RW(RW)
  ) u_mac_unit (
    .clk     (clk),
    .resetn  (resetn),
    .en      (state_q == MAC),
    .sel_init(k_q == '0),
    .a       (mem_a[i_q][k_q]),
    .b       (mem_b[k_q][j_q]),
    .init    (acc_init),
    .acc     (acc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < K; c++)
          mem_a[r][c] <= '0;
    end else if (matrix_a_we && host_wr_ok) begin
      mem_a[row_addr_a][col_addr_a] <= data_in_a;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < N; c++)
          mem_b[r][c] <= '0;
    end else if (matrix_b_we && host_wr_ok) begin
      mem_b[row_addr_b][col_addr_b] <= data_in_b;
    end
  end

  // Engine writeback and host writes never overlap: host writes need IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          mem_c[r][c] <= '0;
    end else if (state_q == WB) begin
      mem_c[i_q][j_q] <= acc;
    end else if (matrix_c_we && host_wr_ok) begin
      mem_c[row_addr_c][col_addr_c] <= data_in_c;
    end
  end

  assign data_out_a = matrix_a_re ? mem_a[row_addr_a][col_addr_a] : '0;
  assign data_out_b = matrix_b_re ? mem_b[row_addr_b][col_addr_b] : '0;
  assign data_out_c = matrix_c_re ? mem_c[row_addr_c][col_addr_c] : '0;

endmodule

// File: tb/tb_mac_matmul_engine.sv
// Directed bench for mac_matmul_engine with a matrix-level reference model
// and a per-cycle compare process.
module tb_mac_matmul_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] data_in_a, data_in_b;
  logic [65:0] data_in_c;
  logic [1:0]  row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c;
  logic        matrix_a_we, matrix_b_we, matrix_c_we;
  logic        matrix_a_re, matrix_b_re, matrix_c_re;
  logic [31:0] data_out_a, data_out_b;
  logic [65:0] data_out_c;
  logic        start, accumulate, busy, done;

  always #5 clk = ~clk;

  mac_matmul_engine dut (
    .clk(clk), .resetn(resetn),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .data_in_c(data_in_c),
    .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
    .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
    .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
    .matrix_a_we(matrix_a_we), .matrix_b_we(matrix_b_we), .matrix_c_we(matrix_c_we),
    .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re), .matrix_c_re(matrix_c_re),
    .data_out_a(data_out_a), .data_out_b(data_out_b), .data_out_c(data_out_c),
    .start(start), .accumulate(accumulate), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];
  logic [65:0] mc [4][4];
  int run_left = 0;
  bit exp_done = 1'b0;
  bit acc_mode = 1'b0;
  bit chk_on = 1'b0;
  int done_seen = 0;

  int av [4][4] = '{'{4,3,2,5}, '{3,4,5,2}, '{5,2,4,3}, '{2,5,3,4}};
  int bv [4][4] = '{'{7,6,5,8}, '{6,7,8,5}, '{8,5,7,6}, '{5,8,6,7}};
  int cexp [4][4] = '{'{87,95,88,94}, '{95,87,94,88}, '{94,88,87,95}, '{88,94,95,87}};

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish();
    logic [65:0] s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = acc_mode ? mc[i][j] : 66'd0;
        for (int k = 0; k < 4; k++) s = s + 66'(ma[i][k]) * 66'(mb[k][j]);
        mc[i][j] = s;
      end
  endtask

  task automatic model_clear();
    run_left = 0;
    exp_done = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = '0; mb[r][c] = '0; mc[r][c] = '0;
      end
  endtask

  // One clock: the model reacts to the inputs that were present at the edge.
  task automatic step();
    bit nd;
    @(posedge clk);
    if (resetn) begin
      nd = 1'b0;
      if (run_left > 0) begin
        run_left--;
        if (run_left == 0) begin
          model_finish();
          nd = 1'b1;
        end
      end else begin
        if (matrix_a_we) ma[row_addr_a][col_addr_a] = data_in_a;
        if (matrix_b_we) mb[row_addr_b][col_addr_b] = data_in_b;
        if (matrix_c_we) mc[row_addr_c][col_addr_c] = data_in_c;
        if (start) begin
          run_left = 80;
          acc_mode = accumulate;
        end
      end
      exp_done = nd;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 66'(busy), 66'(run_left > 0));
      check("done", 66'(done), 66'(exp_done));
      if (done) done_seen++;
      check("out_a", 66'(data_out_a), matrix_a_re ? 66'(ma[row_addr_a][col_addr_a]) : 66'd0);
      check("out_b", 66'(data_out_b), matrix_b_re ? 66'(mb[row_addr_b][col_addr_b]) : 66'd0);
      if (run_left == 0)
        check("out_c", data_out_c, matrix_c_re ? mc[row_addr_c][col_addr_c] : 66'd0);
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_clear();
    check("busy_in_reset", 66'(busy), 66'd0);
    check("done_in_reset", 66'(done), 66'd0);
    repeat (2) step();
    resetn = 1'b1;
    step();
  endtask

  task automatic load_ab();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        row_addr_a = 2'(r); col_addr_a = 2'(c); data_in_a = 32'(av[r][c]);
        row_addr_b = 2'(r); col_addr_b = 2'(c); data_in_b = 32'(bv[r][c]);
        matrix_a_we = 1'b1; matrix_b_we = 1'b1;
        step();
      end
    matrix_a_we = 1'b0; matrix_b_we = 1'b0;
  endtask

  task automatic chk_c(input int r, input int c, input logic [65:0] exp);
    row_addr_c = 2'(r); col_addr_c = 2'(c); matrix_c_re = 1'b1;
    #1;
    check($sformatf("c[%0d][%0d]", r, c), data_out_c, exp);
    step();
    matrix_c_re = 1'b0;
  endtask

  task automatic chk_c_table();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) chk_c(r, c, 66'(cexp[r][c]));
  endtask

  task automatic run(input bit acc, input bit disturb);
    int cnt;
    int d0;
    d0 = done_seen;
    accumulate = acc; start = 1'b1;
    step();
    start = 1'b0; accumulate = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (disturb && cnt == 10) begin
        row_addr_a = 2'd1; col_addr_a = 2'd1; data_in_a = 32'd999; matrix_a_we = 1'b1;
        row_addr_c = 2'd2; col_addr_c = 2'd2; data_in_c = 66'd12345; matrix_c_we = 1'b1;
        start = 1'b1; accumulate = 1'b1;
        step();
        matrix_a_we = 1'b0; matrix_c_we = 1'b0; start = 1'b0; accumulate = 1'b0;
      end else begin
        step();
      end
    end
    check("busy_cycles", 66'(cnt), 66'd80);
    check("done_after_run", 66'(done), 66'd1);
    step();
    check("done_pulses", 66'(done_seen - d0), 66'd1);
  endtask

  initial begin
    int d0;
    resetn = 1'b0;
    data_in_a = '0; data_in_b = '0; data_in_c = '0;
    row_addr_a = '0; col_addr_a = '0; row_addr_b = '0; col_addr_b = '0;
    row_addr_c = '0; col_addr_c = '0;
    matrix_a_we = 1'b0; matrix_b_we = 1'b0; matrix_c_we = 1'b0;
    matrix_a_re = 1'b0; matrix_b_re = 1'b0; matrix_c_re = 1'b0;
    start = 1'b0; accumulate = 1'b0;
    #2;
    do_reset();
    chk_on = 1'b1;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        row_addr_a = 2'(r); col_addr_a = 2'(c);
        row_addr_b = 2'(r); col_addr_b = 2'(c);
        row_addr_c = 2'(r); col_addr_c = 2'(c);
        matrix_a_re = 1'b1; matrix_b_re = 1'b1; matrix_c_re = 1'b1;
        #1;
        check("rst_a", 66'(data_out_a), 66'd0);
        check("rst_b", 66'(data_out_b), 66'd0);
        check("rst_c", data_out_c, 66'd0);
        step();
      end
    matrix_a_re = 1'b0; matrix_b_re = 1'b0; matrix_c_re = 1'b0;

    load_ab();
    run(1'b0, 1'b0);
    chk_c_table();

    run(1'b1, 1'b0);
    chk_c(0, 0, 66'd174);
    chk_c(3, 3, 66'd174);
    chk_c(0, 1, 66'd190);

    run(1'b0, 1'b1);
    chk_c_table();
    row_addr_a = 2'd1; col_addr_a = 2'd1; matrix_a_re = 1'b1;
    #1;
    check("a11_kept", 66'(data_out_a), 66'd4);
    step();
    matrix_a_re = 1'b0;

    // Abort a run with reset after 30 busy cycles.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    d0 = done_seen;
    do_reset();
    repeat (100) step();
    check("no_done_after_abort", 66'(done_seen - d0), 66'd0);
    chk_c(0, 0, 66'd0);
    chk_c(1, 2, 66'd0);
    chk_c(3, 3, 66'd0);
    load_ab();
    run(1'b0, 1'b0);
    chk_c_table();

    // Wrap-around in accumulate mode.
    do_reset();
    row_addr_a = 2'd0; col_addr_a = 2'd0; data_in_a = 32'hFFFF_FFFF; matrix_a_we = 1'b1;
    row_addr_b = 2'd0; col_addr_b = 2'd0; data_in_b = 32'hFFFF_FFFF; matrix_b_we = 1'b1;
    row_addr_c = 2'd0; col_addr_c = 2'd0; data_in_c = {66{1'b1}};     matrix_c_we = 1'b1;
    step();
    matrix_a_we = 1'b0; matrix_b_we = 1'b0; matrix_c_we = 1'b0;
    run(1'b1, 1'b0);
    chk_c(0, 0, 66'h0_FFFF_FFFE_0000_0000);
    chk_c(0, 1, 66'd0);
    chk_c(1, 0, 66'd0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_matmul_engine.md
# mac_matmul_engine

Parametrised successor to the matrix store used by the MAC datapath. Holds matrices A (M×K), B (K×N) and C (M×N) with host read/write ports. Adds an on-chip sequential multiply-accumulate engine that computes C = A·B, or C += A·B in accumulate mode, on a start pulse and signals completion. Sits between the host loader/readback logic and the MAC result consumers.

## Interface
- M, 4, rows of A and C
- K, 4, inner dimension (columns of A, rows of B)
- N, 4, columns of B and C
- DATA_WIDTH_INIT_MATRIX, 32, element width of A and B (unsigned)
- DATA_WIDTH_RESULT_MATRIX, 2*DATA_WIDTH_INIT_MATRIX+$clog2(K), element width of C

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset; asynchronous, active-low
- data_in_a / data_in_b  in  DATA_WIDTH_INIT_MATRIX  host write data for A / B
- data_in_c  in  DATA_WIDTH_RESULT_MATRIX  host write data for C
- row_addr_a, col_addr_a  in  $clog2(M), $clog2(K)  A address
- row_addr_b, col_addr_b  in  $clog2(K), $clog2(N)  B address
- row_addr_c, col_addr_c  in  $clog2(M), $clog2(N)  C address
- matrix_a_we / matrix_b_we / matrix_c_we  in  1  host write enables
- matrix_a_re / matrix_b_re / matrix_c_re  in  1  host read enables
- data_out_a / data_out_b  out  DATA_WIDTH_INIT_MATRIX  host read data
- data_out_c  out  DATA_WIDTH_RESULT_MATRIX  host read data
- start  in  1  launch computation (sampled in IDLE only)
- accumulate  in  1  mode, sampled with start: 0 = overwrite C, 1 = add into C
- busy  out  1  engine running
- done  out  1  single-cycle completion pulse

## Operation
- Host write: on the rising edge with we=1, mem[row][col] <= data_in. Honoured only when busy=0; dropped while busy.
- Host read: combinational. data_out = mem[row][col] when re=1, else 0. Permitted while busy; C may show partial results.
- FSM states: IDLE, MAC, WB.
  - IDLE: start=1 latches accumulate, clears i=j=k=0, and moves to MAC. busy=0.
  - MAC: one product per cycle, A[i][k]*B[k][j]. At k=0, acc <= init + product, where init = C[i][j] if accumulate else 0. Otherwise acc <= acc + product. Goes to WB after k=K-1.
  - WB: C[i][j] <= acc. j increments; on j wrap, i increments. After i=M-1, j=N-1, the FSM returns to IDLE and pulses done. Otherwise it returns to MAC with k=0.
- Arithmetic is unsigned. Accumulation wraps modulo 2^DATA_WIDTH_RESULT_MATRIX; there is no saturation and no flag.
- start while busy is ignored. start and a host write in the same IDLE cycle: the write commits, and the engine sees the written value.
- Reset (any time, including mid-run) does the following:
  - FSM to IDLE, busy=0, done=0, counters and acc to 0.
  - All three memories cleared to 0.

## Timing
- Reset values: busy=0, done=0. data_out_* are 0 since all memories are 0.
- start seen at edge t gives busy=1 from t+1. The engine runs M·N·(K+1) cycles (80 for 4×4×4).
- The final WB edge drops busy and raises done for exactly one cycle. A new start can be accepted in that cycle.
- C[i][j] is visible on data_out_c the cycle after its WB edge.
- Host read path has zero latency; write-to-read latency is 1 edge.

## Structure
- Package mac_mem_pkg holds:
  - state enum (IDLE, MAC, WB)
  - address-width localparams derived via $clog2
  - default width constants
- One sub-module, mac_unit: registered multiply-add with acc init/select inputs and acc output, width DATA_WIDTH_RESULT_MATRIX.
- The top holds the three memory arrays, the host ports, counters and the FSM.

## Test plan
- Reset then read all A/B/C -> every data_out is 0. busy=0 and done=0.
- Load A={{4,3,2,5},{3,4,5,2},{5,2,4,3},{2,5,3,4}} and B={{7,6,5,8},{6,7,8,5},{8,5,7,6},{5,8,6,7}}, then start with accumulate=0:
  - busy high for exactly 80 cycles, then a 1-cycle done.
  - C={{87,95,88,94},{95,87,94,88},{94,88,87,95},{88,94,95,87}}.
- Same operands, then start with accumulate=1 -> C[0][0]=174, C[3][3]=174, C[0][1]=190.
- Host writes to A/C during busy, plus a second start mid-run:
  - writes are ignored.
  - the result equals the case above.
  - exactly one done.
- Assert resetn low at cycle 30 of a run:
  - busy drops immediately and done never fires.
  - C reads 0.
  - a fresh load/start then gives the correct results.
- A[0][0]=B[0][0]=32'hFFFFFFFF, rest 0, C[0][0] preloaded to 2^66-1, accumulate=1 -> C[0][0] wraps to (2^64-2^33+1)-1.
